// File: rtl/alu_apb_regif.sv
// APB3 register front-end for the ALU core: operand/opcode registers, launch FSM with timeout, sticky status.
// Optional macro ALU_REGIF_PSLVERR_EN enables pslverr responses for illegal accesses.
module alu_apb_regif #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int OPC_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              alu_start,
    output logic [DATA_W-1:0] alu_opa,
    output logic [DATA_W-1:0] alu_opb,
    output logic [OPC_W-1:0]  alu_opcode,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_ovf
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic [DATA_W-1:0] opa_reg, opb_reg, result_reg;
    logic [DATA_W-1:0] alu_opa_reg, alu_opb_reg;
    logic [OPC_W-1:0]  alu_opcode_reg;
    logic done_reg, ovf_reg, err_busy_reg, timeout_reg;

    // Address decode: only word indices 0..7 with zero upper bits are candidates.
    logic       upper_ok;
    logic [2:0] idx;
    logic       sel_opa, sel_opb, sel_status, sel_result, sel_go;

    assign upper_ok   = (paddr[ADDR_W-1:3] == '0);
    assign idx        = paddr[2:0];
    assign sel_opa    = upper_ok && (idx == 3'd0);
    assign sel_opb    = upper_ok && (idx == 3'd1);
    assign sel_status = upper_ok && (idx == 3'd4);
    assign sel_result = upper_ok && (idx == 3'd5);
    assign sel_go     = upper_ok && (idx == 3'd6);

    logic busy, access, result_stall, commit, wr_commit, rd_commit;
    logic go_accept, go_busy;
    logic capture, timed_out;
    logic [4:1] w1c;

    assign busy         = (state_reg != IDLE);
    assign access       = psel && penable;
    // A RESULT read during an operation is held off until the FSM is back in IDLE.
    assign result_stall = access && !pwrite && sel_result && busy;
    assign pready       = !result_stall;
    assign commit       = access && pready;
    assign wr_commit    = commit && pwrite;
    assign rd_commit    = commit && !pwrite;
    assign go_accept    = wr_commit && sel_go && (state_reg == IDLE);
    assign go_busy      = wr_commit && sel_go && busy;
    assign w1c          = (wr_commit && sel_status) ? pwdata[4:1] : 4'b0000;

    assign alu_start  = (state_reg == LAUNCH);
    assign alu_opa    = alu_opa_reg;
    assign alu_opb    = alu_opb_reg;
    assign alu_opcode = alu_opcode_reg;

`ifdef ALU_REGIF_PSLVERR_EN
    logic err_access;
    always_comb begin
        err_access = 1'b0;
        if (!(sel_opa || sel_opb || sel_status || sel_result || sel_go))
            err_access = 1'b1;
        else if (pwrite && sel_result)
            err_access = 1'b1;
        else if (!pwrite && sel_go)
            err_access = 1'b1;
        else if (pwrite && sel_go && busy)
            err_access = 1'b1;
    end
    assign pslverr = commit && err_access;
`else
    assign pslverr = 1'b0;
`endif

    // Read data is combinational and only non-zero on the completing cycle of a read.
    always_comb begin
        prdata = '0;
        if (rd_commit) begin
            if (sel_opa)
                prdata = opa_reg;
            else if (sel_opb)
                prdata = opb_reg;
            else if (sel_status)
                prdata = DATA_W'({timeout_reg, err_busy_reg, ovf_reg, done_reg, busy});
            else if (sel_result)
                prdata = result_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        timed_out  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (go_accept)
                    state_next = LAUNCH;
            end
            LAUNCH: begin
                state_next = WAIT;
                cnt_next   = '0;
            end
            WAIT: begin
                if (alu_done) begin
                    state_next = IDLE;
                    capture    = 1'b1;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    state_next = IDLE;
                    timed_out  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa_reg        <= '0;
            opb_reg        <= '0;
            result_reg     <= '0;
            alu_opa_reg    <= '0;
            alu_opb_reg    <= '0;
            alu_opcode_reg <= '0;
        end else begin
            if (wr_commit && sel_opa)
                opa_reg <= pwdata;
            if (wr_commit && sel_opb)
                opb_reg <= pwdata;
            if (go_accept) begin
                alu_opa_reg    <= opa_reg;
                alu_opb_reg    <= opb_reg;
                alu_opcode_reg <= pwdata[OPC_W-1:0];
            end
            if (capture)
                result_reg <= alu_result;
        end
    end

    // Sticky status bits: a set in the same cycle as a write-1-clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
            err_busy_reg <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            if (capture)
                done_reg <= 1'b1;
            else if (go_accept || w1c[1])
                done_reg <= 1'b0;

            if (capture && alu_ovf)
                ovf_reg <= 1'b1;
            else if (go_accept || w1c[2])
                ovf_reg <= 1'b0;

            if (go_busy)
                err_busy_reg <= 1'b1;
            else if (w1c[3])
                err_busy_reg <= 1'b0;

            if (timed_out)
                timeout_reg <= 1'b1;
            else if (w1c[4])
                timeout_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_apb_regif.sv
// Directed self-checking bench for alu_apb_regif: APB transfers, a scripted core model and
// hand-computed expectations; define ALU_REGIF_PSLVERR_EN to expect error responses.
module tb_alu_apb_regif;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr, alu_start;
    logic [31:0] alu_opa, alu_opb;
    logic [3:0]  alu_opcode;
    logic        alu_done, alu_ovf;
    logic [31:0] alu_result;

    int compared   = 0;
    int mismatched = 0;

`ifdef ALU_REGIF_PSLVERR_EN
    localparam logic [31:0] ERR_EN = 32'd1;
`else
    localparam logic [31:0] ERR_EN = 32'd0;
`endif

    always #5 clk = ~clk;

    alu_apb_regif #(.DATA_W(32), .ADDR_W(32), .OPC_W(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .alu_start(alu_start), .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_opcode(alu_opcode),
        .alu_done(alu_done), .alu_result(alu_result), .alu_ovf(alu_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
        $display("check %-14s observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Called at the start of a cycle; returns at the start of the cycle after the completing access.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic [31:0] err, output int waits);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (pready === 1'b1) break;
            waits++;
            if (waits > 200) begin
                compared++;
                mismatched++;
                $error("FAIL pready_bound: observed stall %0d expected <= 200", waits);
                break;
            end
        end
        rdata = prdata;
        err   = {31'd0, pslverr};
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // Core model: called at the start of the launch cycle S; the core registers start at the end
    // of S and raises done for one cycle L cycles later (cycle S+L+1). Returns at start of S+L+2.
    task automatic core_respond(input int lat, input logic [31:0] res, input logic ov);
        @(negedge clk);
        check("alu_start", {31'd0, alu_start}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("start_pulse", {31'd0, alu_start}, 32'd0);
        repeat (lat) @(posedge clk);
        #1;
        alu_done = 1'b1; alu_result = res; alu_ovf = ov;
        @(posedge clk); #1;
        alu_done = 1'b0; alu_result = 32'd0; alu_ovf = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, er;
        int          w;

        reset_n = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'd0; pwdata = 32'd0;
        alu_done = 1'b0; alu_result = 32'd0; alu_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pready", {31'd0, pready}, 32'd1);
        check("rst_prdata", prdata, 32'd0);
        check("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check("rst_start", {31'd0, alu_start}, 32'd0);
        check("rst_opa", alu_opa, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic operation: 5 op 3 -> 8
        apb_xfer(1'b1, 32'd0, 32'd5, rd, er, w);
        apb_xfer(1'b1, 32'd1, 32'd3, rd, er, w);
        apb_xfer(1'b0, 32'd1, 32'd0, rd, er, w);
        check("opb_readback", rd, 32'd3);
        apb_xfer(1'b1, 32'd6, 32'd0, rd, er, w);
        core_respond(4, 32'd8, 1'b0);
        check("t2_opa", alu_opa, 32'd5);
        check("t2_opb", alu_opb, 32'd3);
        apb_xfer(1'b0, 32'd4, 32'd0, rd, er, w);
        check("t2_status", rd, 32'h2);
        apb_xfer(1'b0, 32'd5, 32'd0, rd, er, w);
        check("t2_result", rd, 32'd8);

        // Reset in the middle of WAIT
        apb_xfer(1'b1, 32'd6, 32'd1, rd, er, w);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        check("t1_start", {31'd0, alu_start}, 32'd0);
        check("t1_pready", {31'd0, pready}, 32'd1);
        check("t1_opa", alu_opa, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        apb_xfer(1'b0, 32'd4, 32'd0, rd, er, w);
        check("t1_status", rd, 32'h0);
        apb_xfer(1'b0, 32'd5, 32'd0, rd, er, w);
        check("t1_result", rd, 32'd0);

        // RESULT read straight after GO stalls until the core answers
        apb_xfer(1'b1, 32'd6, 32'd2, rd, er, w);
        fork
            begin
                logic [31:0] r3, e3;
                int          w3;
                apb_xfer(1'b0, 32'd5, 32'd0, r3, e3, w3);
                check("t3_stall", w3, 32'd7);
                check("t3_prdata", r3, 32'h1234_5678);
            end
            core_respond(6, 32'h1234_5678, 1'b1);
        join
        apb_xfer(1'b0, 32'd4, 32'd0, rd, er, w);
        check("t3_status", rd, 32'h6);

        // Back-to-back GO: second one refused, err_busy set then cleared
        apb_xfer(1'b1, 32'd6, 32'h9841_C0C6, rd, er, w);
        fork
            begin
                logic [31:0] r4, e4;
                int          w4;
                apb_xfer(1'b1, 32'd6, 32'd3, r4, e4, w4);
                check("t4_go2_err", e4, ERR_EN);
            end
            core_respond(3, 32'hAAAA_0000, 1'b0);
        join
        check("t4_opcode", {28'd0, alu_opcode}, 32'h6);
        apb_xfer(1'b0, 32'd4, 32'd0, rd, er, w);
        check("t4_status", rd, 32'hA);
        apb_xfer(1'b1, 32'd4, 32'h8, rd, er, w);
        apb_xfer(1'b0, 32'd4, 32'd0, rd, er, w);
        check("t4_w1c", rd, 32'h2);

        // Timeout: GO in cycle N, WAIT spans N+2..N+65, IDLE from N+66
        apb_xfer(1'b1, 32'd6, 32'd0, rd, er, w);
        repeat (63) @(posedge clk);
        #1;
        apb_xfer(1'b0, 32'd5, 32'd0, rd, er, w);
        check("t5_stall", w, 32'd1);
        check("t5_result", rd, 32'hAAAA_0000);
        apb_xfer(1'b0, 32'd4, 32'd0, rd, er, w);
        check("t5_status", rd, 32'h10);
        apb_xfer(1'b1, 32'd4, 32'h10, rd, er, w);
        apb_xfer(1'b0, 32'd4, 32'd0, rd, er, w);
        check("t5_w1c", rd, 32'h0);

        // Illegal accesses
        apb_xfer(1'b1, 32'd0, 32'hCAFE_F00D, rd, er, w);
        check("t6_opa_err", er, 32'd0);
        apb_xfer(1'b1, 32'h20, 32'h1111_1111, rd, er, w);
        check("t6_hi_err", er, ERR_EN);
        apb_xfer(1'b0, 32'd0, 32'd0, rd, er, w);
        check("t6_opa_keep", rd, 32'hCAFE_F00D);
        apb_xfer(1'b1, 32'd5, 32'h0000_FFFF, rd, er, w);
        check("t6_res_wr_err", er, ERR_EN);
        apb_xfer(1'b0, 32'd5, 32'd0, rd, er, w);
        check("t6_res_keep", rd, 32'hAAAA_0000);
        apb_xfer(1'b0, 32'd6, 32'd0, rd, er, w);
        check("t6_go_rd", rd, 32'd0);
        check("t6_go_rd_err", er, ERR_EN);
        apb_xfer(1'b0, 32'd3, 32'd0, rd, er, w);
        check("t6_unmapped", rd, 32'd0);
        check("t6_unmap_err", er, ERR_EN);
        apb_xfer(1'b0, 32'h24, 32'd0, rd, er, w);
        check("t6_hi_rd", rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
